// File: rtl/uart_rx_word.sv
// uart_rx_word: oversampling UART receiver that rebuilds a WORD_W-bit word
// from consecutive character frames, using the transmitter's csr encoding.
// Ports: tick (clock, OVERSAMPLE per bit), rst (sync, active high),
//   rx (serial in, idle high), csr ([3:0] data bits, 0=8; [4] two stop;
//   [5] parity en; [6] odd parity), rx_data/rx_valid/rx_err (word out),
//   parity_err/frame_err (per-frame one-cycle error pulses).
module uart_rx_word #(
  parameter int OVERSAMPLE = 16,
  parameter int WORD_W     = 32
) (
  input  logic              tick,
  input  logic              rst,
  input  logic              rx,
  input  logic [31:0]       csr,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int WBW = $clog2(WORD_W + 1);

  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_END  = SCW'(OVERSAMPLE - 1);
  localparam logic [WBW-1:0] WB_FULL = WBW'(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t state, state_n;

  logic              rx_q, rxs;
  logic [SCW-1:0]    sc, sc_n;
  logic [3:0]        bc, bc_n;
  logic [6:0]        fcsr, fcsr_n;
  logic [WBW-1:0]    wb, wb_n;
  logic [WORD_W-1:0] word, word_n;
  logic              par, par_n;
  logic              ferr, ferr_n;
  logic              acc, acc_n;
  logic [WORD_W-1:0] rx_data_n;
  logic              rx_valid_n, rx_err_n;
  logic              pe_n, fe_n;
  logic              end_frame;
  logic              at_end;
  logic              mism;
  logic [3:0]        nb_m1;
  logic              unused_csr;

  assign unused_csr = ^csr[31:7];

  assign at_end = (sc == SC_END);
  assign nb_m1  = (fcsr[3:0] == 4'd0) ? 4'd7 : fcsr[3:0] - 4'd1;
  // Parity bit must equal XOR(data) for even, its complement for odd.
  assign mism   = rxs ^ par ^ fcsr[6];

  always_ff @(posedge tick) begin
    if (rst) begin
      rx_q       <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      sc         <= '0;
      bc         <= '0;
      fcsr       <= '0;
      wb         <= '0;
      word       <= '0;
      par        <= 1'b0;
      ferr       <= 1'b0;
      acc        <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_q       <= rx;
      rxs        <= rx_q;
      state      <= state_n;
      sc         <= sc_n;
      bc         <= bc_n;
      fcsr       <= fcsr_n;
      wb         <= wb_n;
      word       <= word_n;
      par        <= par_n;
      ferr       <= ferr_n;
      acc        <= acc_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      rx_err     <= rx_err_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    state_n    = state;
    sc_n       = sc;
    bc_n       = bc;
    fcsr_n     = fcsr;
    wb_n       = wb;
    word_n     = word;
    par_n      = par;
    ferr_n     = ferr;
    acc_n      = acc;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_err_n   = rx_err;
    pe_n       = 1'b0;
    fe_n       = 1'b0;
    end_frame  = 1'b0;

    if (state != IDLE)
      sc_n = at_end ? '0 : sc + SCW'(1);

    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          sc_n    = '0;
        end
      end
      START: begin
        if (sc == SC_MID) begin
          sc_n = '0;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            fcsr_n  = csr[6:0];
            bc_n    = '0;
            par_n   = 1'b0;
            ferr_n  = 1'b0;
          end
        end
      end
      DATA: begin
        if (at_end) begin
          par_n = par ^ rxs;
          // Bits past the word width still feed parity but are dropped.
          if (wb < WB_FULL) begin
            word_n = word | ({{(WORD_W-1){1'b0}}, rxs} << wb);
            wb_n   = wb + WBW'(1);
          end
          bc_n = bc + 4'd1;
          if (bc == nb_m1) begin
            bc_n    = '0;
            state_n = fcsr[5] ? PARITY : STOP1;
          end
        end
      end
      PARITY: begin
        if (at_end) begin
          pe_n    = mism;
          ferr_n  = ferr | mism;
          state_n = STOP1;
        end
      end
      STOP1: begin
        if (at_end) begin
          fe_n = !rxs;
          if (fcsr[4]) begin
            ferr_n  = ferr | !rxs;
            state_n = STOP2;
          end else begin
            end_frame = 1'b1;
          end
        end
      end
      STOP2: begin
        if (at_end) begin
          fe_n      = !rxs;
          end_frame = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Last stop sample: fold frame errors into the word and maybe emit it.
    if (end_frame) begin
      state_n = IDLE;
      acc_n   = acc | ferr | !rxs;
      if (wb >= WB_FULL) begin
        rx_data_n  = word;
        rx_valid_n = 1'b1;
        rx_err_n   = acc_n;
        wb_n       = '0;
        word_n     = '0;
        acc_n      = 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- UART receiver: the stage directly downstream of the transmitter. Consumes its serial `out` line and rebuilds the 32-bit word that was sent as consecutive character frames.
- Uses the same `csr` frame encoding as the transmitter, so a TX→RX loopback with a shared `csr` is lossless.
- Delivers each completed word to the register interface with a one-cycle valid pulse, plus per-frame parity/framing error flags.

Parameters:
- OVERSAMPLE, 16, `tick` cycles per bit period. Even, ≥4.
- WORD_W, 32, width of the assembled word.

Ports:
- tick  in  1  Oversampling clock, OVERSAMPLE cycles per bit. Single clock domain.
- rst  in  1  Synchronous, active-high reset, sampled on posedge tick.
- rx  in  1  Serial input, idle high. Asynchronous to `tick`.
- csr  in  32  [3:0] data bits per frame (0 means 8); [4] two stop bits; [5] parity enable; [6] odd parity (0 = even).
- rx_data  out  32  Assembled word. Stable between rx_valid pulses.
- rx_valid  out  1  One-cycle pulse: rx_data holds a new word.
- rx_err  out  1  Qualified by rx_valid: at least one frame of that word had a parity or framing error.
- parity_err  out  1  One-cycle pulse: parity mismatch in the current frame.
- frame_err  out  1  One-cycle pulse: a stop-bit sample read 0.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_err=0, parity_err=0, frame_err=0, state=IDLE, bit/tick counters=0, partial word and accumulated error cleared, synchronizer flops=1.
- rx passes through a 2-flop synchronizer; rxs is the synchronized value. All decisions use rxs.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. A tick counter `sc` runs 0..OVERSAMPLE-1 in every non-IDLE state.
- IDLE: rxs==0 → START, sc=0.
- START: sample at sc==OVERSAMPLE/2-1.
  - rxs==1 → false start, return to IDLE, no flags raised.
  - rxs==0 → latch csr[6:0] for the whole frame, go to DATA, sc=0.
  - From here on, every sample is taken at sc==OVERSAMPLE-1, i.e. mid-bit.
- DATA: take NB samples, where NB = latched csr[3:0] (0 → 8), LSB first.
  - Each sample is written to word bit `wb`, then wb increments. `wb` counts total data bits received in the current word.
  - Bits arriving when wb ≥ WORD_W are discarded but still enter the parity calculation.
  - After NB samples: go to PARITY if csr[5], else STOP1.
- PARITY: expected = XOR(frame data bits) for even parity; the complement for odd. A mismatch pulses parity_err one cycle after the sample. Then go to STOP1.
- STOP1: rxs==0 pulses frame_err. Then go to STOP2 if csr[4], else frame end.
- STOP2: same check as STOP1, then frame end.
- Frame end (the cycle after the last stop sample):
  - Any parity_err/frame_err in the frame is OR'd into a word-error accumulator.
  - If wb ≥ WORD_W: rx_data ← assembled word, rx_valid=1 for one cycle, rx_err ← accumulator. Then clear wb, the partial word and the accumulator.
  - State → IDLE, which can detect the next start bit immediately, since the mid-stop sample leaves half a bit of margin.
- Word completion: the word completes in the frame where wb reaches WORD_W; excess bits in that frame are dropped.
  - 8-bit: 4 frames.
  - 5-bit: 7 frames, last 3 bits dropped.
  - 7-bit: 5 frames, last 3 bits dropped.
- Errored frames still contribute their data bits; data is never silently discarded. rx_err flags the word.
- A csr change takes effect only at the next confirmed start bit. wb carries across frames, so a mid-word format change is allowed.
- Reset mid-frame or mid-word: abort immediately. The partial word is lost, no rx_valid is issued, and the next word starts at wb=0.
- rx held low (break): after the frame's stop sample raises frame_err, IDLE sees rxs==0 and re-enters START. No lockup.

Test Plan:
- OVERSAMPLE=16, csr=0x08 (8N1), frames 0x44,0x33,0x22,0x11 → rx_valid once, rx_data=0x11223344, rx_err=0. The valid pulse comes 1 tick after the stop sample of the 4th frame.
- csr=0x28 (8E1): frames 0x01,0x00,0x00,0x00, first frame's parity bit driven 0 → parity_err pulse in frame 1; word 0x00000001 with rx_err=1.
- csr=0x18 (8N2), second stop bit of frame 3 driven low → one frame_err pulse; rx_valid after frame 4 with rx_err=1; correct data.
- csr=0x05 (5N1), 7 frames of 0x1F → rx_data=0xFFFFFFFF after frame 7, 3 bits discarded.
- rx low glitch of 5 ticks while idle → no state exit beyond START, no flags, and the following valid word is received correctly.
- Assert rst for 1 tick during frame 2, then send 4 fresh frames → only one rx_valid, carrying the fresh word.
